add_seq_ctrl: RTL and testbench
===============================

Name: add_seq_ctrl

Overview:
Sequencer that performs NBYTES-wide add/subtract by time-multiplexing one external combinational 8-bit adder (adder8: a, b, cin -> sum, cout).
- Captures operands through a valid/ready request port.
- Feeds byte slices LSB-first to the adder, one per cycle, chaining carry between slices.
- Returns the assembled result on a valid/ready response port.
- Sits between the operand producer and the shared adder8 datapath.

Parameters:
NBYTES, 4, operand/result width in bytes (W = 8*NBYTES); legal range 1..16

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request operands valid
req_ready  output  1  block can accept request (IDLE only)
req_a  input  W  operand A
req_b  input  W  operand B
req_cin  input  1  carry-in (used only when req_sub=0)
req_sub  input  1  1 = A - B, 0 = A + B + cin
add_a  output  8  byte slice of A to adder8.a
add_b  output  8  byte slice of B (inverted if sub) to adder8.b
add_cin  output  1  chained carry to adder8.cin
add_sum  input  8  adder8.sum
add_cout  input  1  adder8.cout
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_sum  output  W  result
rsp_cout  output  1  final carry (sub: 1 = no borrow)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - req_ready=1 after reset release.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, busy=0, add_a=0, add_b=0, add_cin=0.
  - Byte index and carry registers are cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at edge T:
    - Capture req_a into a_reg.
    - Capture req_b into b_reg, or ~req_b if req_sub=1.
    - carry = req_sub ? 1 : req_cin.
    - idx = 0; clear rsp_sum; go to RUN.
  - req_cin is ignored when req_sub=1.
- RUN:
  - Combinationally drive add_a = a_reg[8*idx +: 8], add_b = b_reg[8*idx +: 8], add_cin = carry.
  - Each edge:
    - rsp_sum[8*idx +: 8] <= add_sum.
    - carry <= add_cout.
    - idx <= idx+1.
  - On the edge where idx == NBYTES-1: rsp_cout <= add_cout; go to DONE.
  - RUN lasts exactly NBYTES cycles.
  - rsp_valid rises after edge T+NBYTES, giving fixed latency NBYTES cycles from accept.
- DONE:
  - rsp_valid=1.
  - rsp_sum and rsp_cout are held stable while rsp_ready=0, for unbounded backpressure.
  - On rsp_valid && rsp_ready: go to IDLE. rsp_valid falls; rsp_sum/rsp_cout retain their value until the next accept.
- Outside RUN: add_a, add_b, add_cin are driven to 0.
- req_ready=0 in RUN and DONE. req_valid is ignored there, and the operands must be held by the producer.
- Minimum request-to-request spacing is NBYTES+2 cycles: accept, NBYTES of RUN, DONE handshake, then IDLE.
- Overflow: the result wraps modulo 2^W; overflow is reported only via rsp_cout.
- NBYTES=1: RUN is one cycle, and the behaviour reduces to a registered adder8.
- Reset asserted mid-RUN or in DONE:
  - Immediate return to IDLE with all reset values.
  - The partial result is discarded and no rsp_valid is produced.
- Adder inputs/outputs are treated as purely combinational. No register sits between add_* outputs and add_sum/add_cout.

Test Plan:
1. NBYTES=4, add A=0x000000FF, B=0x00000001, cin=0 -> rsp_sum=0x00000100, rsp_cout=0; rsp_valid high exactly 4 cycles after accept edge; add_cin sequence 0,1,0,0.
2. Add A=0xFFFFFFFF, B=0x00000000, cin=1 -> rsp_sum=0x00000000, rsp_cout=1; carry propagates through all 4 bytes.
3. Sub A=0x00000005, B=0x00000007 -> rsp_sum=0xFFFFFFFE, rsp_cout=0. Sub A=0x00000007, B=0x00000005 with req_cin=0 -> rsp_sum=0x00000002, rsp_cout=1.
4. Backpressure: A=0x12345678, B=0x11111111 add, rsp_ready held low 3 cycles -> rsp_valid=1 and rsp_sum=0x23456789 stable throughout; req_ready=0 and a concurrent req_valid is not accepted; release rsp_ready -> IDLE next cycle, req_ready=1.
5. Reset mid-operation: assert rst_n=0 after 2 RUN cycles -> outputs immediately reset values, busy=0. After release, a new request A=1, B=1 gives rsp_sum=0x00000002 with no stale bytes.
6. Back-to-back: req_valid held high with rsp_ready=1 and two requests -> second accepted exactly NBYTES+2 cycles after first; both results correct; add_* outputs are 0 in IDLE/DONE cycles.

Source files
------------

// File: rtl/add_seq_ctrl_if.sv
// Request/response handshake bundle for add_seq_ctrl.
// The master side produces operands and consumes results.
interface add_seq_ctrl_if #(
    parameter int unsigned NBYTES = 4
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [8*NBYTES-1:0]   req_a;
    logic [8*NBYTES-1:0]   req_b;
    logic                  req_cin;
    logic                  req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [8*NBYTES-1:0]   rsp_sum;
    logic                  rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// Multi-byte add/subtract sequencer that time-multiplexes one external
// combinational 8-bit adder, one byte slice per cycle, LSB first.
module add_seq_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    add_seq_ctrl_if.slave bus,
    output logic [7:0]    add_a,
    output logic [7:0]    add_b,
    output logic          add_cin,
    input  logic [7:0]    add_sum,
    input  logic          add_cout,
    output logic          busy
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, b_q, sum_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q, cout_q;
    logic           accept, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b0;
        add_a         = 8'h00;
        add_b         = 8'h00;
        add_cin       = 1'b0;
        accept        = 1'b0;
        last          = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy    = 1'b1;
                add_a   = a_q[8*idx_q +: 8];
                add_b   = b_q[8*idx_q +: 8];
                add_cin = carry_q;
                last    = (idx_q == LastIdx);
                if (last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy          = 1'b1;
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted at capture and carry seeded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.req_a;
            b_q     <= bus.req_sub ? ~bus.req_b : bus.req_b;
            carry_q <= bus.req_sub | bus.req_cin;
            idx_q   <= '0;
            sum_q   <= '0;
        end else if (state_q == StRun) begin
            sum_q[8*idx_q +: 8] <= add_sum;
            carry_q             <= add_cout;
            idx_q               <= idx_q + 1'b1;
            if (last) begin
                cout_q <= add_cout;
            end
        end
    end

    assign bus.rsp_sum  = sum_q;
    assign bus.rsp_cout = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl with a behavioural adder8 and an
// arithmetic reference model.
module tb_add_seq_ctrl;
    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;
    localparam int          BOUND = 4 * NB + 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] obs_a    [32];
    logic [7:0] obs_b    [32];
    logic       obs_cin  [32];
    logic       obs_busy [32];

    add_seq_ctrl_if #(.NBYTES(NB)) bus ();

    add_seq_ctrl #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .busy     (busy)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // {cout, sum}: add is plain (W+1)-bit addition, sub is wrap-around difference
    // with cout meaning "no borrow".
    function automatic logic [W:0] ref_result(input logic [W-1:0] a, b,
                                              input logic cin, sub);
        logic [W:0] r;
        if (sub) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
        return r;
    endfunction

    // Carry into byte k is the carry/no-borrow out of the low 8*k bits.
    function automatic logic ref_carry_in(input logic [W-1:0] a, b,
                                          input logic cin, sub, input int k);
        logic [W:0] m, la, lb;
        m  = ({{W{1'b0}}, 1'b1} << (8 * k)) - 1'b1;
        la = {1'b0, a} & m;
        lb = {1'b0, b} & m;
        if (sub) return la >= lb;
        return (la + lb + {{W{1'b0}}, cin}) > m;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int k = 0; k < NB; k++) v[8*k +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic do_accept(input logic [W-1:0] a, b, input logic cin, sub,
                             output logic rdy);
        @(negedge clk);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        bus.req_sub   = sub;
        bus.req_valid = 1'b1;
        rdy = bus.req_ready;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Called just after the accept edge; returns edges until rsp_valid seen.
    task automatic collect(output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.rsp_valid && lat < BOUND) begin
            obs_a[lat]    = add_a;
            obs_b[lat]    = add_b;
            obs_cin[lat]  = add_cin;
            obs_busy[lat] = busy;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_a = '0; bus.req_b = '0; bus.req_cin = 1'b0; bus.req_sub = 1'b0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.rsp_valid, bus.rsp_cout, busy, add_cin} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b c=%b busy=%b cin=%b exp all 0",
                     bus.rsp_valid, bus.rsp_cout, busy, add_cin);
        end
        checks++;
        if ({bus.rsp_sum, add_a, add_b} !== '0) begin
            errors++;
            $display("FAIL reset_data got sum=%h a=%h b=%h exp 0", bus.rsp_sum, add_a, add_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", bus.req_ready);
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] ta [4] = '{32'h000000FF, 32'hFFFFFFFF, 32'h00000005, 32'h00000007};
        logic [W-1:0] tb_ [4] = '{32'h00000001, 32'h00000000, 32'h00000007, 32'h00000005};
        logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] a, b, bx;
        logic [W:0]   exp;
        logic         cin, sub, rdy;
        int           lat;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            if (n < 4) begin
                a = ta[n]; b = tb_[n]; cin = tc[n]; sub = ts[n];
            end else begin
                a = rand_word(); b = rand_word();
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end
            exp = ref_result(a, b, cin, sub);
            bx  = sub ? ~b : b;
            do_accept(a, b, cin, sub, rdy);
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL arith_ready n=%0d got %b exp 1", n, rdy);
            end
            collect(lat);
            checks++;
            if (lat != NB) begin
                errors++;
                $display("FAIL arith_latency n=%0d got %0d exp %0d", n, lat, NB);
            end
            checks++;
            if ({bus.rsp_cout, bus.rsp_sum} !== exp) begin
                errors++;
                $display("FAIL arith_result n=%0d a=%h b=%h cin=%b sub=%b got %b_%h exp %b_%h",
                         n, a, b, cin, sub, bus.rsp_cout, bus.rsp_sum, exp[W], exp[W-1:0]);
            end
            for (int k = 0; k < NB && k < lat; k++) begin
                checks++;
                if ({obs_busy[k], obs_cin[k], obs_a[k], obs_b[k]} !==
                    {1'b1, ref_carry_in(a, b, cin, sub, k), a[8*k +: 8], bx[8*k +: 8]}) begin
                    errors++;
                    $display("FAIL arith_slice n=%0d k=%0d got busy=%b cin=%b a=%h b=%h exp 1 %b %h %h",
                             n, k, obs_busy[k], obs_cin[k], obs_a[k], obs_b[k],
                             ref_carry_in(a, b, cin, sub, k), a[8*k +: 8], bx[8*k +: 8]);
                end
            end
            checks++;
            if ({add_a, add_b, add_cin} !== 17'h0) begin
                errors++;
                $display("FAIL arith_done_adder n=%0d got a=%h b=%h cin=%b exp 0",
                         n, add_a, add_b, add_cin);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.req_ready, busy} !== 3'b010 ||
                {bus.rsp_cout, bus.rsp_sum} !== exp) begin
                errors++;
                $display("FAIL arith_idle n=%0d got v=%b rdy=%b busy=%b res=%b_%h exp 0 1 0 %b_%h",
                         n, bus.rsp_valid, bus.req_ready, busy, bus.rsp_cout, bus.rsp_sum,
                         exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic rdy;
        int   lat;
        bus.rsp_ready = 1'b0;
        do_accept(32'h12345678, 32'h11111111, 1'b0, 1'b0, rdy);
        collect(lat);
        checks++;
        if (lat != NB) begin
            errors++;
            $display("FAIL bp_latency got %0d exp %0d", lat, NB);
        end
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_cout} !== 3'b100 ||
                bus.rsp_sum !== 32'h23456789) begin
                errors++;
                $display("FAIL bp_hold i=%0d got v=%b rdy=%b cout=%b sum=%h exp 1 0 0 23456789",
                         i, bus.rsp_valid, bus.req_ready, bus.rsp_cout, bus.rsp_sum);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.req_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release got v=%b rdy=%b busy=%b exp 0 1 0",
                     bus.rsp_valid, bus.req_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_stale_accept got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        logic rdy;
        int   lat;
        bus.rsp_ready = 1'b1;
        do_accept(32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0, rdy);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_cout, busy, add_cin} !== 4'b0 ||
            {bus.rsp_sum, add_a, add_b} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got v=%b c=%b busy=%b sum=%h a=%h b=%h cin=%b exp 0",
                     bus.rsp_valid, bus.rsp_cout, busy, bus.rsp_sum, add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_accept(32'h00000001, 32'h00000001, 1'b0, 1'b0, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got %b exp 1", rdy);
        end
        collect(lat);
        checks++;
        if (lat != NB || bus.rsp_sum !== 32'h00000002 || bus.rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_result got lat=%0d sum=%h cout=%b exp %0d 00000002 0",
                     lat, bus.rsp_sum, bus.rsp_cout, NB);
        end
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        logic [W:0]   exp1, exp2;
        logic         got1, rdy;
        int           cyc, acc2, lat;
        a1 = rand_word(); b1 = rand_word();
        a2 = rand_word(); b2 = rand_word();
        exp1 = ref_result(a1, b1, 1'b1, 1'b0);
        exp2 = ref_result(a2, b2, 1'b0, 1'b1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_a = a1; bus.req_b = b1; bus.req_cin = 1'b1; bus.req_sub = 1'b0;
        bus.req_valid = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready1 got %b exp 1", bus.req_ready);
        end
        @(posedge clk);
        cyc = 0; got1 = 1'b0; acc2 = -1;
        while (acc2 < 0 && cyc < BOUND) begin
            @(negedge clk);
            if (!busy || bus.rsp_valid) begin
                checks++;
                if ({add_a, add_b, add_cin} !== 17'h0) begin
                    errors++;
                    $display("FAIL b2b_adder_idle cyc=%0d got a=%h b=%h cin=%b exp 0",
                             cyc, add_a, add_b, add_cin);
                end
            end
            rdy = bus.req_ready;
            if (bus.rsp_valid && !got1) begin
                got1 = 1'b1;
                checks++;
                if ({bus.rsp_cout, bus.rsp_sum} !== exp1) begin
                    errors++;
                    $display("FAIL b2b_result1 got %b_%h exp %b_%h",
                             bus.rsp_cout, bus.rsp_sum, exp1[W], exp1[W-1:0]);
                end
                bus.req_a = a2; bus.req_b = b2; bus.req_cin = 1'b0; bus.req_sub = 1'b1;
            end
            @(posedge clk);
            cyc++;
            if (rdy && got1) acc2 = cyc;
        end
        #1 bus.req_valid = 1'b0;
        checks++;
        if (acc2 != NB + 2) begin
            errors++;
            $display("FAIL b2b_spacing got %0d exp %0d", acc2, NB + 2);
        end
        collect(lat);
        checks++;
        if (lat != NB || {bus.rsp_cout, bus.rsp_sum} !== exp2) begin
            errors++;
            $display("FAIL b2b_result2 got lat=%0d res=%b_%h exp %0d %b_%h",
                     lat, bus.rsp_cout, bus.rsp_sum, NB, exp2[W], exp2[W-1:0]);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_final_idle got busy=%b rdy=%b exp 0 1", busy, bus.req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
